cpu_mem_arbiter: RTL
====================

// Module: cpu_mem_arbiter
// PURPOSE
//  Sits between custom_cpu and the single-port memory bus.
//  Merges the CPU's instruction-fetch channel and data load/store channel into one valid/ready request/response bus.
//  One transaction is outstanding at a time. Requests are registered; responses are steered back to their owner.
//  Provides two grant counters for cpu_perf_cnt.
// PARAMETERS
//  ADDR_W  32  request address width
//  DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
//  clk              input   1         clock
//  rst              input   1         asynchronous, active-low reset
//  PC               input   ADDR_W    inst fetch address
//  Inst_Req_Valid   input   1         inst request valid
//  Inst_Req_Ready   output  1         inst request accepted
//  Instruction      output  DATA_W    fetched instruction
//  Inst_Valid       output  1         instruction valid
//  Inst_Ready       input   1         CPU ready for instruction
//  Address          input   ADDR_W    data address (word aligned)
//  MemWrite         input   1         store request
//  MemRead          input   1         load request
//  Write_data       input   DATA_W    store data
//  Write_strb       input   DATA_W/8  store byte strobes
//  Mem_Req_Ready    output  1         data request accepted
//  Read_data        output  DATA_W    load data
//  Read_data_Valid  output  1         load data valid
//  Read_data_Ready  input   1         CPU ready for load data
//  mem_req_valid    output  1         bus request valid
//  mem_req_ready    input   1         bus accepts request
//  mem_addr         output  ADDR_W    bus address
//  mem_wen          output  1         bus write
//  mem_wdata        output  DATA_W    bus write data
//  mem_wstrb        output  DATA_W/8  bus write strobes
//  mem_rdata        input   DATA_W    bus read data
//  mem_rdata_valid  input   1         bus read data valid
//  mem_rdata_ready  output  1         arbiter ready for read data
//  inst_grant_cnt   output  32        inst requests accepted (wraps)
//  data_grant_cnt   output  32        data requests accepted (wraps)
// BEHAVIOUR
//  States (one-hot): IDLE, IREQ, DREQ, IRSP, DRSP. Reset -> IDLE.
//  Reset values: all registered outputs 0, all counters 0, mem_req_valid=0.
//  Reset mid-transaction abandons it; any bus response arriving after reset is dropped (IDLE has mem_rdata_ready=0).
//  IDLE:
//   - If MemRead|MemWrite: Mem_Req_Ready=1 this cycle; latch Address/Write_data/Write_strb/MemWrite; data_grant_cnt+1; -> DREQ.
//   - Else if Inst_Req_Valid: Inst_Req_Ready=1; latch PC, mem_wen=0; inst_grant_cnt+1; -> IREQ.
//   - Data wins when both are pending; the instruction request waits.
//   - MemRead and MemWrite both high is treated as a write.
//  IREQ/DREQ: mem_req_valid=1, driven from latched registers and stable until mem_req_ready.
//   - On handshake: IREQ -> IRSP; DREQ -> DRSP if read, else IDLE (stores have no response).
//  IRSP: Instruction=mem_rdata, Inst_Valid=mem_rdata_valid, mem_rdata_ready=Inst_Ready. -> IDLE on valid&ready.
//  DRSP: Read_data=mem_rdata, Read_data_Valid=mem_rdata_valid, mem_rdata_ready=Read_data_Ready. -> IDLE on valid&ready.
//  Response path is combinational pass-through: 0 added cycles. Request path adds exactly 1 cycle (the accept cycle).
//  Upstream ready signals are 0 in every state except IDLE. Valids to the CPU are 0 outside their own RSP state.
//  Minimum store occupancy is 2 cycles; minimum load/fetch occupancy is 3 cycles.
//  Counters are free-running 32-bit: 0xFFFFFFFF+1 -> 0.
// STRUCTURE
//  Shared package holds the state localparams (one-hot codes) and ADDR_W/DATA_W defaults.
//  Single module, no sub-modules. Request register bank and FSM live in one file.
// TESTING
//  - Fetch: PC=0x100, mem_req_ready=1, rdata=0x24020005 valid 2 cycles later -> Inst_Req_Ready pulses once; Instruction=0x24020005 with Inst_Valid; inst_grant_cnt=1.
//  - Store: addr 0x40, data 0xDEADBEEF, strb 0xF; mem_req_ready held low 3 cycles -> mem_req_valid held with stable addr/data; back to IDLE after handshake; no Read_data_Valid.
//  - Simultaneous: MemRead@0x80 and Inst_Req_Valid same cycle -> data served first; fetch accepted only after DRSP completes.
//  - Backpressure: Read_data_Ready low 4 cycles while mem_rdata_valid=1 -> mem_rdata_ready=0, Read_data_Valid=1 held, state DRSP.
//  - Reset in IREQ: assert rst low -> mem_req_valid=0 immediately; counters=0; a stray mem_rdata_valid afterwards is not forwarded.
//  - Wrap: preload data_grant_cnt=0xFFFFFFFF via force, one store -> 0x00000000.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// cpu_mem_arbiter shared definitions.
// One-hot state codes and default bus widths.
package cpu_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam int ST_W = 5;

  localparam int B_IDLE = 0;
  localparam int B_IREQ = 1;
  localparam int B_DREQ = 2;
  localparam int B_IRSP = 3;
  localparam int B_DRSP = 4;

  localparam logic [ST_W-1:0] S_IDLE = 5'b00001;
  localparam logic [ST_W-1:0] S_IREQ = 5'b00010;
  localparam logic [ST_W-1:0] S_DREQ = 5'b00100;
  localparam logic [ST_W-1:0] S_IRSP = 5'b01000;
  localparam logic [ST_W-1:0] S_DRSP = 5'b10000;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges CPU fetch and load/store onto one bus.
// One transaction in flight; data side wins ties in IDLE.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   PC,
  input  logic                Inst_Req_Valid,
  output logic                Inst_Req_Ready,
  output logic [DATA_W-1:0]   Instruction,
  output logic                Inst_Valid,
  input  logic                Inst_Ready,
  input  logic [ADDR_W-1:0]   Address,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [DATA_W-1:0]   Write_data,
  input  logic [DATA_W/8-1:0] Write_strb,
  output logic                Mem_Req_Ready,
  output logic [DATA_W-1:0]   Read_data,
  output logic                Read_data_Valid,
  input  logic                Read_data_Ready,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdata_valid,
  output logic                mem_rdata_ready,
  output logic [31:0]         inst_grant_cnt,
  output logic [31:0]         data_grant_cnt
);

  localparam int STRB_W = DATA_W / 8;

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              wen_q, wen_d;
  logic [31:0]       icnt_q, icnt_d;
  logic [31:0]       dcnt_q, dcnt_d;

  assign mem_req_valid  = state_q[B_IREQ] | state_q[B_DREQ];
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wstrb      = wstrb_q;
  assign Instruction    = mem_rdata;
  assign Read_data      = mem_rdata;
  assign inst_grant_cnt = icnt_q;
  assign data_grant_cnt = dcnt_q;

  // Next-state, request capture and response steering.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    wen_d           = wen_q;
    icnt_d          = icnt_q;
    dcnt_d          = dcnt_q;
    Inst_Req_Ready  = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Inst_Valid      = 1'b0;
    Read_data_Valid = 1'b0;
    mem_rdata_ready = 1'b0;
    unique case (1'b1)
      state_q[B_IDLE]: begin
        if (MemRead | MemWrite) begin
          Mem_Req_Ready = 1'b1;
          addr_d        = Address;
          wdata_d       = Write_data;
          wstrb_d       = Write_strb;
          wen_d         = MemWrite;
          dcnt_d        = dcnt_q + 32'd1;
          state_d       = S_DREQ;
        end else if (Inst_Req_Valid) begin
          Inst_Req_Ready = 1'b1;
          addr_d         = PC;
          wstrb_d        = '0;
          wen_d          = 1'b0;
          icnt_d         = icnt_q + 32'd1;
          state_d        = S_IREQ;
        end
      end
      state_q[B_IREQ]: begin
        if (mem_req_ready) state_d = S_IRSP;
      end
      state_q[B_DREQ]: begin
        if (mem_req_ready) state_d = wen_q ? S_IDLE : S_DRSP;
      end
      state_q[B_IRSP]: begin
        Inst_Valid      = mem_rdata_valid;
        mem_rdata_ready = Inst_Ready;
        if (mem_rdata_valid && Inst_Ready) state_d = S_IDLE;
      end
      state_q[B_DRSP]: begin
        Read_data_Valid = mem_rdata_valid;
        mem_rdata_ready = Read_data_Ready;
        if (mem_rdata_valid && Read_data_Ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request register bank and grant counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wen_q   <= wen_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

endmodule
